// File: rtl/ram_1w1r_sync.sv
// Simple dual-port RAM: one write port and one registered read port.
// Read data appears one edge after ra is presented. Contents have no reset.
module ram_1w1r_sync #(
    parameter int DATA_WIDTH = 16,
    parameter int DATA_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  wem,
    input  logic [DATA_DEPTH-1:0] wa,
    input  logic [DATA_WIDTH-1:0] wd,
    input  logic [DATA_DEPTH-1:0] ra,
    output logic [DATA_WIDTH-1:0] rd
);

    logic [DATA_WIDTH-1:0] mem [2**DATA_DEPTH];

    always_ff @(posedge clk) begin
        if (wem) begin
            mem[wa] <= wd;
        end
        rd <= mem[ra];
    end

endmodule

// File: rtl/fifo_sync_thresh.sv
// Single-clock FIFO with FWFT/registered read, exact fill, programmable almost flags and sticky errors.
// Status flags are registered from the next fill; full accepts a write only alongside an accepted read.
module fifo_sync_thresh #(
    parameter int DATA_WIDTH = 16,
    parameter int DATA_DEPTH = 4,
    parameter bit FWFT       = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  srst,
    input  logic                  we,
    input  logic                  re,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  nempty,
    output logic                  full,
    output logic [DATA_DEPTH:0]   fill,
    input  logic [DATA_DEPTH:0]   af_level,
    input  logic [DATA_DEPTH:0]   ae_level,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int                    CAPACITY = 1 << DATA_DEPTH;
    localparam logic [DATA_DEPTH:0]   CAP_W    = (DATA_DEPTH+1)'(CAPACITY);
    localparam logic [DATA_DEPTH:0]   FILL_ONE = (DATA_DEPTH+1)'(1);
    localparam logic [DATA_DEPTH-1:0] PTR_ONE  = DATA_DEPTH'(1);

    logic [DATA_DEPTH-1:0] wa, ra, wa_next, ra_next;
    logic [DATA_DEPTH:0]   fill_next;
    logic                  rd_acc, wr_acc;
    logic [DATA_WIDTH-1:0] din_q, ram_q, head;
    logic                  bypass;

    always_comb begin
        rd_acc    = re & nempty;
        wr_acc    = we & (~full | rd_acc);
        wa_next   = wr_acc ? wa + PTR_ONE : wa;
        ra_next   = rd_acc ? ra + PTR_ONE : ra;
        fill_next = fill;
        if (wr_acc & ~rd_acc) begin
            fill_next = fill + FILL_ONE;
        end else if (rd_acc & ~wr_acc) begin
            fill_next = fill - FILL_ONE;
        end
        // RAM cannot return a word written on the same edge, so the input register covers it
        head = bypass ? din_q : ram_q;
    end

    // The read port always looks at the post-edge head address
    ram_1w1r_sync #(
        .DATA_WIDTH (DATA_WIDTH),
        .DATA_DEPTH (DATA_DEPTH)
    ) u_ram (
        .clk (clk),
        .wem (wr_acc),
        .wa  (wa),
        .wd  (data_in),
        .ra  (ra_next),
        .rd  (ram_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wa           <= '0;
            ra           <= '0;
            fill         <= '0;
            nempty       <= 1'b0;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            din_q        <= '0;
            bypass       <= 1'b1;
        end else if (srst) begin
            wa           <= '0;
            ra           <= '0;
            fill         <= '0;
            nempty       <= 1'b0;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            din_q        <= '0;
            bypass       <= 1'b1;
        end else begin
            wa           <= wa_next;
            ra           <= ra_next;
            fill         <= fill_next;
            nempty       <= (fill_next != '0);
            full         <= (fill_next == CAP_W);
            almost_full  <= (fill_next >= af_level);
            almost_empty <= (fill_next <= ae_level);
            overflow     <= (we & ~wr_acc) | (overflow & ~clr_err);
            underflow    <= (re & ~nempty) | (underflow & ~clr_err);
            if (wr_acc) begin
                din_q  <= data_in;
                bypass <= (wa == ra_next);
            end else if (rd_acc) begin
                bypass <= 1'b0;
            end
        end
    end

    if (FWFT) begin : g_fwft
        assign data_out = head;
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] dout_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout_q <= '0;
            end else if (srst) begin
                dout_q <= '0;
            end else if (rd_acc) begin
                dout_q <= head;
            end
        end

        assign data_out = dout_q;
    end

endmodule

// File: tb/tb_fifo_sync_thresh.sv
// Drives an FWFT and a registered-read FIFO with shared stimulus and checks both against a queue model.
module tb_fifo_sync_thresh;

    logic        clk = 1'b0;
    logic        rst, srst, we, re, clr_err;
    logic [15:0] data_in;
    logic [4:0]  af_level, ae_level;

    logic [15:0] dout1, dout0;
    logic        nempty1, full1, af1, ae1, ovf1, unf1;
    logic        nempty0, full0, af0, ae0, ovf0, unf0;
    logic [4:0]  fill1, fill0;

    int checks = 0;
    int errors = 0;

    logic [15:0] mq[$];
    bit          m_ovf, m_unf, m_af, m_ae, pristine;
    logic [15:0] m_dout0;

    always #5 clk = ~clk;

    fifo_sync_thresh #(.DATA_WIDTH(16), .DATA_DEPTH(4), .FWFT(1'b1)) dut_fwft (
        .clk(clk), .rst(rst), .srst(srst), .we(we), .re(re), .data_in(data_in),
        .data_out(dout1), .nempty(nempty1), .full(full1), .fill(fill1),
        .af_level(af_level), .ae_level(ae_level), .almost_full(af1), .almost_empty(ae1),
        .overflow(ovf1), .underflow(unf1), .clr_err(clr_err)
    );

    fifo_sync_thresh #(.DATA_WIDTH(16), .DATA_DEPTH(4), .FWFT(1'b0)) dut_reg (
        .clk(clk), .rst(rst), .srst(srst), .we(we), .re(re), .data_in(data_in),
        .data_out(dout0), .nempty(nempty0), .full(full0), .fill(fill0),
        .af_level(af_level), .ae_level(ae_level), .almost_full(af0), .almost_empty(ae0),
        .overflow(ovf0), .underflow(unf0), .clr_err(clr_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_flags();
        m_af = (mq.size() >= int'(af_level));
        m_ae = (mq.size() <= int'(ae_level));
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
        m_af     = 1'b0;
        m_ae     = 1'b1;
        m_dout0  = 16'h0000;
        pristine = 1'b1;
    endtask

    // One clock edge of the FIFO rules, evaluated on the pre-edge queue
    task automatic model_edge();
        bit rd, wr;
        if (srst) begin
            model_reset();
        end else begin
            rd = re && (mq.size() > 0);
            wr = we && ((mq.size() < 16) || rd);
            if (we && !wr)       m_ovf = 1'b1;
            else if (clr_err)    m_ovf = 1'b0;
            if (re && !rd)       m_unf = 1'b1;
            else if (clr_err)    m_unf = 1'b0;
            if (rd) m_dout0 = mq.pop_front();
            if (wr) begin
                mq.push_back(data_in);
                pristine = 1'b0;
            end
            model_flags();
        end
    endtask

    task automatic check_all();
        chk("fill",         32'(fill1),   32'(mq.size()));
        chk("nempty",       32'(nempty1), 32'(mq.size() > 0));
        chk("full",         32'(full1),   32'(mq.size() == 16));
        chk("almost_full",  32'(af1),     32'(m_af));
        chk("almost_empty", 32'(ae1),     32'(m_ae));
        chk("overflow",     32'(ovf1),    32'(m_ovf));
        chk("underflow",    32'(unf1),    32'(m_unf));
        if (mq.size() > 0)  chk("fwft_head", 32'(dout1), 32'(mq[0]));
        else if (pristine)  chk("fwft_idle", 32'(dout1), 32'h0);
        chk("reg_dout",     32'(dout0),   32'(m_dout0));
        chk("reg_fill",     32'(fill0),   32'(mq.size()));
        chk("reg_flags",    32'({nempty0, full0, af0, ae0, ovf0, unf0}),
            32'({mq.size() > 0, mq.size() == 16, m_af, m_ae, m_ovf, m_unf}));
    endtask

    task automatic step(input logic w, input logic r, input logic [15:0] d,
                        input logic s, input logic c);
        we = w; re = r; data_in = d; srst = s; clr_err = c;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic async_reset_check();
        we = 1'b1; re = 1'b1; data_in = 16'hDEAD; srst = 1'b0; clr_err = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; srst = 1'b0; we = 1'b0; re = 1'b0; clr_err = 1'b0;
        data_in = '0; af_level = 5'd12; ae_level = 5'd3;
        model_reset();
        #1;
        check_all();
        #2 rst = 1'b0;

        // Fill to capacity, then one rejected write
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 16'(i), 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0010, 1'b0, 1'b0);

        // Drain, extra read, then clear both sticky flags
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);

        // Full FIFO with simultaneous write/read across pointer wrap
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 16'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 16'hAA00 | 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 16'h0, 1'b0, 1'b0);

        // Registered-read output from a freshly cleared FIFO
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 16'h1234, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);

        // Synchronous clear beats a concurrent write and read
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 16'($urandom), 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'h5555, 1'b1, 1'b0);

        // Threshold moved under a static fill
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'($urandom), 1'b0, 1'b0);
        af_level = 5'd8;
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        af_level = 5'd12;
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);

        // Random traffic with alternating fill/drain bias
        for (int n = 0; n < 1500; n++) begin
            int wp, rp;
            wp = ((n / 200) % 2 == 0) ? 75 : 35;
            rp = 110 - wp;
            if ($urandom_range(0, 39) == 0) begin
                af_level = 5'($urandom_range(0, 16));
                ae_level = 5'($urandom_range(0, 16));
            end
            step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp, 16'($urandom),
                 $urandom_range(0, 299) == 0, $urandom_range(0, 24) == 0);
            if (n == 700) async_reset_check();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
